// File: rtl/pio_pkg.sv
// Definitions shared by the Avalon-MM PIO blocks (input/button and output variants).
// Holds the bus width and the input-PIO word-address map.
package pio_pkg;

  localparam int PIO_BUS_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/pio_debounce_bit.sv
// One pin: SYNC_STAGES-deep synchronizer, plus a stable-time filter when BUTTON_PIO_IN_DEBOUNCE_EN is defined.
// Latency SYNC_STAGES cycles (+DEBOUNCE_CYCLES when filtered); free-running, no backpressure.
module pio_debounce_bit #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_stable
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef BUTTON_PIO_IN_DEBOUNCE_EN
  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // Any return to the current stable level restarts the stable-time count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= IDLE_LEVEL;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;
`else
  assign o_stable = w_sync;
`endif

endmodule

// File: rtl/button_pio_in.sv
// Avalon-MM button PIO: filtered pin levels, press capture (W1C), masked level irq; debounce via BUTTON_PIO_IN_DEBOUNCE_EN.
// Read latency 1 cycle, writes land the next cycle; no waitrequest, the slave never stalls.
module button_pio_in
  import pio_pkg::*;
#(
  parameter int   WIDTH           = 8,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [WIDTH-1:0]     keys_export,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [PIO_BUS_W-1:0] avs_writedata,
  output logic [PIO_BUS_W-1:0] avs_readdata,
  output logic                 irq
);

  logic [WIDTH-1:0]     w_stable;
  logic [WIDTH-1:0]     w_press;
  logic [WIDTH-1:0]     w_clr_bits;
  logic                 w_wr_mask;
  logic                 w_wr_clr;
  logic [PIO_BUS_W-1:0] w_rdmux;

  logic [WIDTH-1:0]     r_stable_q;
  logic [WIDTH-1:0]     r_irqmask;
  logic [WIDTH-1:0]     r_edgecap;
  logic [PIO_BUS_W-1:0] r_readdata;
  logic                 r_irq;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_db (
      .i_clk    (clk_clk),
      .i_rst_n  (reset_reset_n),
      .i_pin    (keys_export[i]),
      .o_stable (w_stable[i])
    );
  end

  // A press is a change whose previous level was the released level.
  assign w_press    = (r_stable_q ^ w_stable) & ~(r_stable_q ^ {WIDTH{IDLE_LEVEL}});
  assign w_wr_mask  = avs_write && (avs_address == ADDR_IRQMASK);
  assign w_wr_clr   = avs_write && (avs_address == ADDR_EDGECAP);
  assign w_clr_bits = w_wr_clr ? avs_writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdmux = '0;
    case (avs_address)
      ADDR_DATA:    w_rdmux[WIDTH-1:0] = w_stable;
      ADDR_RSVD:    w_rdmux            = '0;
      ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
      default:      w_rdmux            = '0;
    endcase
  end

  // Set wins over a same-cycle clear so a press is never lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_stable_q <= {WIDTH{IDLE_LEVEL}};
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_q <= w_stable;
      r_edgecap  <= (r_edgecap & ~w_clr_bits) | w_press;
      r_irq      <= |(r_edgecap & r_irqmask);
      if (w_wr_mask) r_irqmask  <= avs_writedata[WIDTH-1:0];
      if (avs_read)  r_readdata <= w_rdmux;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_button_pio_in.sv
// Directed bench for button_pio_in: reset exit, capture/irq, W1C vs press collision, read timing, debounce, async reset.
// Debounce-specific timing is selected with BUTTON_PIO_IN_DEBOUNCE_EN to match the DUT build.
module tb_button_pio_in;
  import pio_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 16;
`ifdef BUTTON_PIO_IN_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;  // edges from a pin change to edgecapture set
`else
  localparam int LAT = SYNC;
`endif

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic [WIDTH-1:0] keys_export;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  button_pio_in #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .keys_export   (keys_export),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step(1);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    step(1);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic edges_to_irq(input int limit, inout int n);
    while (irq !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    logic        dropped;

    reset_reset_n = 1'b0;
    keys_export   = 8'hFF;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // Reset state and reset exit with buttons released
    step(5);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_reset_n = 1'b1;
    step(100);
    check("exit_irq", {31'b0, irq}, 32'h0);
    bus_read(ADDR_EDGECAP, rd); check("exit_edgecap", rd, 32'h0);
    bus_read(ADDR_DATA, rd);    check("exit_data", rd, 32'h0000_00FF);
    bus_read(ADDR_IRQMASK, rd); check("exit_mask", rd, 32'h0);

    // Press key 3 while unmasking it; irq latency from the pin change
    keys_export   = 8'hF7;
    avs_address   = ADDR_IRQMASK;
    avs_writedata = 32'h08;
    avs_write     = 1'b1;
    step(1);
    avs_write     = 1'b0;
    n = 1;
    edges_to_irq(60, n);
    check("cap_irq_latency", n, LAT + 2);
    bus_read(ADDR_EDGECAP, rd); check("cap_edgecap", rd, 32'h08);
    bus_read(ADDR_DATA, rd);    check("cap_data", rd, 32'hF7);
    bus_read(ADDR_IRQMASK, rd); check("cap_mask", rd, 32'h08);

    // Release leaves the capture alone
    keys_export = 8'hFF;
    step(50);
    bus_read(ADDR_EDGECAP, rd); check("rel_keeps_cap", rd, 32'h08);

    // New press on bit 3 reaches edge detect in the same cycle as a W1C of bit 3
    dropped = 1'b0;
    keys_export = 8'hF7;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      if (irq !== 1'b1) dropped = 1'b1;
    end
    bus_write(ADDR_EDGECAP, 32'h08);
    for (int i = 0; i < 3; i++) begin
      if (irq !== 1'b1) dropped = 1'b1;
      step(1);
    end
    check("coll_irq_held", {31'b0, dropped}, 32'h0);
    bus_read(ADDR_EDGECAP, rd); check("coll_edgecap", rd, 32'h08);

    // Plain clear, then release must not capture
    bus_write(ADDR_EDGECAP, 32'h08);
    bus_read(ADDR_EDGECAP, rd); check("clr_edgecap", rd, 32'h0);
    check("clr_irq", {31'b0, irq}, 32'h0);
    keys_export = 8'hFF;
    step(50);
    bus_read(ADDR_EDGECAP, rd); check("rel_no_cap", rd, 32'h0);

    // Two presses, masked then unmasked, partial W1C
    keys_export = 8'h7E;
    step(50);
    bus_read(ADDR_EDGECAP, rd); check("multi_edgecap", rd, 32'h81);
    check("multi_masked_irq", {31'b0, irq}, 32'h0);
    bus_write(ADDR_IRQMASK, 32'h80);
    step(1);
    check("multi_unmask_irq", {31'b0, irq}, 32'h1);
    bus_write(ADDR_EDGECAP, 32'h01);
    bus_read(ADDR_EDGECAP, rd); check("partial_w1c", rd, 32'h80);
    check("partial_irq", {31'b0, irq}, 32'h1);

    // Back-to-back reads of all four addresses
    avs_read = 1'b1;
    avs_address = ADDR_DATA;    step(1); check("b2b_data", avs_readdata, 32'h7E);
    avs_address = ADDR_RSVD;    step(1); check("b2b_rsvd", avs_readdata, 32'h0);
    avs_address = ADDR_IRQMASK; step(1); check("b2b_mask", avs_readdata, 32'h80);
    avs_address = ADDR_EDGECAP; step(1); check("b2b_edgecap", avs_readdata, 32'h80);
    avs_read = 1'b0;
    avs_address = ADDR_DATA;
    step(3);
    check("rd_hold", avs_readdata, 32'h80);

    // Writes to read-only / reserved words are ignored
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    bus_write(ADDR_DATA, 32'h0);
    bus_read(ADDR_RSVD, rd); check("rsvd_wr_ignored", rd, 32'h0);
    bus_read(ADDR_DATA, rd); check("data_wr_ignored", rd, 32'h7E);

    // Read and write together: write lands, read returns the old value
    avs_address   = ADDR_IRQMASK;
    avs_writedata = 32'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step(1);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    check("rw_pre_value", avs_readdata, 32'h80);
    bus_read(ADDR_IRQMASK, rd); check("rw_written", rd, 32'h55);
    bus_write(ADDR_IRQMASK, 32'hFFFF_FF01);
    bus_read(ADDR_IRQMASK, rd); check("mask_upper_ignored", rd, 32'h01);

    // Glitch filtering (debounce build) or single-cycle pulse capture (direct build)
    bus_write(ADDR_EDGECAP, 32'hFF);
    keys_export = 8'hFF;
    step(50);
    check("pre_glitch_irq", {31'b0, irq}, 32'h0);
`ifdef BUTTON_PIO_IN_DEBOUNCE_EN
    keys_export = 8'hFE;
    step(10);
    keys_export = 8'hFF;
    step(5);
    keys_export = 8'hFE;
    n = 0;
`else
    keys_export = 8'hFE;
    step(1);
    keys_export = 8'hFF;
    n = 1;
`endif
    edges_to_irq(80, n);
    check("glitch_irq_latency", n, LAT + 2);
    bus_read(ADDR_EDGECAP, rd); check("glitch_edgecap", rd, 32'h01);

    // Asynchronous reset mid-debounce with a read pending
    keys_export = 8'hFF;
    step(50);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    keys_export = 8'hFE;
    step(10);
    avs_address = ADDR_DATA;
    avs_read    = 1'b1;
    #2 reset_reset_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_readdata", avs_readdata, 32'h0);
    keys_export = 8'hFF;
    step(1);
    avs_read = 1'b0;
    check("arst_read_discarded", avs_readdata, 32'h0);
    step(3);
    reset_reset_n = 1'b1;
    step(50);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    bus_read(ADDR_DATA, rd);    check("post_rst_data", rd, 32'hFF);
    bus_read(ADDR_EDGECAP, rd); check("post_rst_edgecap", rd, 32'h0);
    bus_read(ADDR_IRQMASK, rd); check("post_rst_mask", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
